pc_fetch: RTL and testbench

Program-counter and fetch sequencer at the consumer end of the `pcop`/`pcvalue` interface driven by the execute units (U-type, branch, jump). It owns the architectural PC and fetches each instruction from instruction memory with a req/ack handshake. It presents the instruction to decode with a valid/ready handshake, then waits for the executing unit's `pcop` to select the next PC. One instruction is in flight at a time; there is no pipelining.

---
 rtl/pc_fetch_if.sv | 27 ++
 rtl/pc_fetch.sv | 109 ++++++++++
 tb/tb_pc_fetch.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// Fetch-side bus of pc_fetch: instruction memory, decode handshake and the
// pcop/pcvalue link to the execute units. pc_fetch uses the master modport.
interface pc_fetch_if;
  logic [31:0] pcvalue;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [1:0]  pcop;
  logic        pcop_valid;
  logic [31:0] pc_target;
  logic [31:0] pc_offset;
  logic        misalign;

  modport master (
    output pcvalue, imem_req, imem_addr, inst, inst_valid, misalign,
    input  imem_ack, imem_rdata, inst_ready, pcop, pcop_valid, pc_target, pc_offset
  );

  modport slave (
    input  pcvalue, imem_req, imem_addr, inst, inst_valid, misalign,
    output imem_ack, imem_rdata, inst_ready, pcop, pcop_valid, pc_target, pc_offset
  );
endinterface

// File: rtl/pc_fetch.sv
// Program counter and single-issue fetch sequencer (IDLE/FETCH/ISSUE/WAIT_EXEC/HALT).
// Optional macro PC_MISALIGN_TRAP_EN: halt with sticky misalign instead of forcing alignment.
module pc_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input logic       clk,
  input logic       rst_n,
  pc_fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_EXEC,
    S_HALT
  } state_t;

  state_t             r_state;
  logic [31:0]        r_pc;
  logic [31:0]        r_inst;
  logic signed [31:0] w_offset;
  logic [31:0]        w_pc_seq;
  logic [31:0]        w_pc_jump;
  logic [31:0]        w_pc_rel;
  logic [31:0]        w_pc_raw;
  logic [31:0]        w_pc_next;
  logic               w_trap;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

  // Candidate next PCs; all sums wrap modulo 2^32.
  always_comb begin
    w_offset  = $signed(bus.pc_offset);
    w_pc_seq  = r_pc + 32'd4;
    w_pc_jump = bus.pc_target & 32'hFFFF_FFFE;
    w_pc_rel  = r_pc + w_offset;
    case (bus.pcop)
      2'b01:   w_pc_raw = w_pc_jump;
      2'b10:   w_pc_raw = w_pc_rel;
      default: w_pc_raw = w_pc_seq;
    endcase
`ifdef PC_MISALIGN_TRAP_EN
    w_trap    = ((bus.pcop == 2'b01) || (bus.pcop == 2'b10)) && (w_pc_raw[1:0] != 2'b00);
    w_pc_next = w_pc_raw;
`else
    w_trap    = 1'b0;
    w_pc_next = align_pc(w_pc_raw);
`endif
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic r_misalign;
  assign bus.misalign = r_misalign;
`else
  assign bus.misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_VECTOR;
      r_inst     <= 32'h0;
`ifdef PC_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (bus.imem_ack) begin
            r_inst  <= bus.imem_rdata;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.inst_ready) r_state <= S_WAIT_EXEC;
        end
        S_WAIT_EXEC: begin
          if (bus.pcop_valid) begin
            if (bus.pcop == 2'b11) begin
              r_state <= S_HALT;
            end else if (w_trap) begin
`ifdef PC_MISALIGN_TRAP_EN
              r_misalign <= 1'b1;
`endif
              r_state    <= S_HALT;
            end else begin
              r_pc    <= w_pc_next;
              r_state <= S_FETCH;
            end
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake strobes decode straight from the state register.
  assign bus.pcvalue    = r_pc;
  assign bus.imem_addr  = r_pc;
  assign bus.imem_req   = (r_state == S_FETCH);
  assign bus.inst_valid = (r_state == S_ISSUE);
  assign bus.inst       = r_inst;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: expected fetch addresses and instructions are
// queued as stimulus is driven and checked when the DUT presents them.
module tb_pc_fetch;
  localparam logic [31:0] RV = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];

  pc_fetch_if bus ();

  pc_fetch #(.RESET_VECTOR(RV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_fetch(input logic [31:0] rdata, input int delay);
    logic [31:0] exp_addr;
    int n = 0;
    while (!bus.imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("fetch_req", {31'b0, bus.imem_req}, 32'd1);
    exp_addr = (q_pc.size() > 0) ? q_pc.pop_front() : 32'hDEAD_BEEF;
    check("fetch_addr", bus.imem_addr, exp_addr);
    check("fetch_pcvalue", bus.pcvalue, exp_addr);
    // pcop_valid while fetching must not disturb the PC
    for (int i = 0; i < delay; i++) begin
      bus.pcop_valid = 1'b1;
      bus.pcop       = 2'b01;
      bus.pc_target  = 32'h5555_0000;
      @(negedge clk);
      check("fetch_hold_req", {31'b0, bus.imem_req}, 32'd1);
      check("fetch_hold_addr", bus.imem_addr, exp_addr);
    end
    bus.pcop_valid = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = rdata;
    q_inst.push_back(rdata);
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
  endtask

  task automatic do_issue(input int delay);
    logic [31:0] exp_inst;
    int n = 0;
    while (!bus.inst_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("issue_valid", {31'b0, bus.inst_valid}, 32'd1);
    check("issue_req_low", {31'b0, bus.imem_req}, 32'd0);
    exp_inst = (q_inst.size() > 0) ? q_inst.pop_front() : 32'hDEAD_BEEF;
    check("issue_inst", bus.inst, exp_inst);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("issue_hold_inst", bus.inst, exp_inst);
      check("issue_hold_valid", {31'b0, bus.inst_valid}, 32'd1);
    end
    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    check("wait_valid_low", {31'b0, bus.inst_valid}, 32'd0);
  endtask

  task automatic do_exec(input logic [1:0] op, input logic [31:0] tgt, input logic [31:0] off,
                         input bit push, input logic [31:0] exp_next);
    bus.pcop       = op;
    bus.pc_target  = tgt;
    bus.pc_offset  = off;
    bus.pcop_valid = 1'b1;
    if (push) q_pc.push_back(exp_next);
    @(negedge clk);
    bus.pcop_valid = 1'b0;
  endtask

  task automatic halt_check(input logic [31:0] exp_pc, input logic exp_mis);
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_req", {31'b0, bus.imem_req}, 32'd0);
      check("halt_valid", {31'b0, bus.inst_valid}, 32'd0);
      check("halt_pc", bus.pcvalue, exp_pc);
    end
    check("halt_misalign", {31'b0, bus.misalign}, {31'b0, exp_mis});
    bus.imem_ack = 1'b0;
  endtask

  initial begin
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hFFFF_FFFF;
    bus.inst_ready = 1'b0;
    bus.pcop       = 2'b00;
    bus.pcop_valid = 1'b0;
    bus.pc_target  = 32'h0;
    bus.pc_offset  = 32'h0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pcvalue", bus.pcvalue, RV);
    check("rst_addr", bus.imem_addr, RV);
    check("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_misalign", {31'b0, bus.misalign}, 32'd0);
    bus.imem_ack = 1'b0;
    rst_n = 1'b1;
    #1 check("idle_req", {31'b0, bus.imem_req}, 32'd0);
    @(negedge clk);
    check("post_rst_req", {31'b0, bus.imem_req}, 32'd1);
    q_pc.push_back(RV);

    // sequential flow
    do_fetch(32'h0000_0297, 0);
    do_issue(0);
    do_exec(2'b00, 32'h0, 32'h0, 1'b1, 32'h0000_1004);
    // delayed ack and decode backpressure, then backward branch
    do_fetch(32'h1234_5678, 5);
    do_issue(2);
    do_exec(2'b10, 32'h0, 32'hFFFF_FFF8, 1'b1, 32'h0000_0FFC);
    do_fetch(32'h0000_006F, 0);
    do_issue(0);
`ifdef PC_MISALIGN_TRAP_EN
    do_exec(2'b01, 32'h8000_0003, 32'h0, 1'b0, 32'h0);
    halt_check(32'h0000_0FFC, 1'b1);
`else
    do_exec(2'b01, 32'h8000_0003, 32'h0, 1'b1, 32'h8000_0000);
    do_fetch(32'h0000_0067, 0);
    do_issue(1);
    do_exec(2'b01, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0013, 0);
    do_issue(0);
    do_exec(2'b00, 32'h0, 32'h0, 1'b1, 32'h0000_0000);
    do_fetch(32'h0000_0073, 3);
    do_issue(0);
    do_exec(2'b11, 32'h0, 32'h0, 1'b0, 32'h0);
    halt_check(32'h0000_0000, 1'b0);
`endif

    // reset asserted while an instruction is being issued
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    q_pc.push_back(RV);
    do_fetch(32'hCAFE_0297, 0);
    check("pre_rst_valid", {31'b0, bus.inst_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, bus.inst_valid}, 32'd0);
    check("async_rst_pc", bus.pcvalue, RV);
    check("async_rst_inst", bus.inst, 32'h0);
    check("async_rst_req", {31'b0, bus.imem_req}, 32'd0);
    void'(q_inst.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_req", {31'b0, bus.imem_req}, 32'd1);
    check("restart_addr", bus.imem_addr, RV);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
